// File: rtl/guess_scoreboard.sv
// Win/lose tally keeper for the guessing game.
// Saturating 2-digit BCD scores shown on a 4-digit muxed 7-seg display.
module guess_scoreboard #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       win,
  input  logic       lose,
  output logic [7:0] win_cnt,
  output logic [7:0] lose_cnt,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam logic [RW-1:0] RTOP = RW'(REFRESH_DIV - 1);

  logic          win_d;
  logic          lose_d;
  logic          win_pulse;
  logic          lose_pulse;
  logic [RW-1:0] rcnt;
  logic [1:0]    idx;
  logic [3:0]    nib;
  logic          tens;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h99) begin
      r = v;
    end else if (v[3:0] == 4'd9) begin
      r = {v[7:4] + 4'd1, 4'd0};
    end else begin
      r = {v[7:4], v[3:0] + 4'd1};
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_dec(input logic [3:0] d);
    logic [6:0] s;
    unique case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign win_pulse  = win & ~win_d;
  assign lose_pulse = lose & ~lose_d;

  // Edge registers track the levels even during clr, so a
  // level spanning the clear is not counted again afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_d    <= 1'b0;
      lose_d   <= 1'b0;
      win_cnt  <= 8'h00;
      lose_cnt <= 8'h00;
    end else begin
      win_d  <= win;
      lose_d <= lose;
      if (clr) begin
        win_cnt  <= 8'h00;
        lose_cnt <= 8'h00;
      end else begin
        if (win_pulse) begin
          win_cnt <= bcd_inc(win_cnt);
        end
        if (lose_pulse) begin
          lose_cnt <= bcd_inc(lose_cnt);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rcnt <= '0;
      idx  <= 2'd0;
    end else if (rcnt == RTOP) begin
      rcnt <= '0;
      idx  <= idx + 2'd1;
    end else begin
      rcnt <= rcnt + 1'b1;
    end
  end

  always_comb begin
    nib  = 4'd0;
    tens = 1'b0;
    unique case (idx)
      2'd0: nib = lose_cnt[3:0];
      2'd1: begin
        nib  = lose_cnt[7:4];
        tens = 1'b1;
      end
      2'd2: nib = win_cnt[3:0];
      2'd3: begin
        nib  = win_cnt[7:4];
        tens = 1'b1;
      end
      default: nib = 4'd0;
    endcase
  end

  always_comb begin
    an  = ~(4'b0001 << idx);
    dp  = (idx != 2'd2);
    seg = seg_dec(nib);
    if (tens && nib == 4'd0) begin
      seg = 7'b1111111;
    end
  end

endmodule

// File: tb/tb_guess_scoreboard.sv
// Scoreboard bench for guess_scoreboard.
// Stimulus queues expectations; a monitor checks them per cycle.
module tb_guess_scoreboard;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clr = 1'b0;
  logic       win = 1'b0;
  logic       lose = 1'b0;
  logic [7:0] win_cnt;
  logic [7:0] lose_cnt;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  guess_scoreboard #(.REFRESH_DIV(4)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .win(win), .lose(lose),
    .win_cnt(win_cnt), .lose_cnt(lose_cnt),
    .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    int         at;
    logic [7:0] w;
    logic [7:0] l;
    bit         disp;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   rel = 0;
  int   vectors = 0;
  int   miscompares = 0;
  logic [7:0] mw = 8'h00;
  logic [7:0] ml = 8'h00;

  logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [6:0] s07_tab [4] = '{7'b1111000, 7'b1111111,
                              7'b1000000, 7'b1111111};

  always @(posedge clk) begin
    exp_t e;
    #1;
    cyc++;
    while (q.size() > 0 && q[0].at <= cyc) begin
      e = q.pop_front();
      vectors++;
      if (e.at < cyc) begin
        miscompares++;
        $display("FAIL %s: stale expectation at=%0d now=%0d",
                 e.name, e.at, cyc);
      end else if (win_cnt !== e.w || lose_cnt !== e.l ||
                   (e.disp && (an !== e.an || seg !== e.seg ||
                               dp !== e.dp))) begin
        miscompares++;
        $display("FAIL %s: got w=%h l=%h an=%b seg=%b dp=%b exp w=%h l=%h an=%b seg=%b dp=%b disp=%0d",
                 e.name, win_cnt, lose_cnt, an, seg, dp,
                 e.w, e.l, e.an, e.seg, e.dp, e.disp);
      end
    end
  end

  function automatic logic [7:0] bcd_next(input logic [7:0] v);
    if (v == 8'h99) return v;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic int idx_at(input int t);
    return ((t - rel) / 4) % 4;
  endfunction

  task automatic drive(input logic w, input logic l,
                       input logic c, input logic r);
    @(negedge clk);
    win = w;
    lose = l;
    clr = c;
    rst = r;
    if (r) rel = cyc + 1;
  endtask

  task automatic push_t(input string n, input logic [7:0] ew,
                        input logic [7:0] el);
    exp_t e;
    e.name = n; e.at = cyc + 1; e.w = ew; e.l = el;
    e.disp = 1'b0; e.an = '0; e.seg = '0; e.dp = 1'b0;
    q.push_back(e);
  endtask

  task automatic push_d(input string n, input logic [7:0] ew,
                        input logic [7:0] el, input logic [3:0] ea,
                        input logic [6:0] es, input logic ed);
    exp_t e;
    e.name = n; e.at = cyc + 1; e.w = ew; e.l = el;
    e.disp = 1'b1; e.an = ea; e.seg = es; e.dp = ed;
    q.push_back(e);
  endtask

  task automatic clear_scores();
    drive(0, 0, 1, 0);
    mw = 8'h00; ml = 8'h00;
    push_t("clr", 8'h00, 8'h00);
    drive(0, 0, 0, 0);
    push_t("clr_idle", 8'h00, 8'h00);
  endtask

  initial begin
    int n;
    // 1. reset
    drive(0, 0, 0, 1);
    push_t("rst_1", 8'h00, 8'h00);
    drive(0, 0, 0, 1);
    push_d("rst_2", 8'h00, 8'h00, 4'b1110, 7'b1000000, 1'b1);
    drive(0, 0, 0, 0);
    push_d("rst_rel", 8'h00, 8'h00, 4'b1110, 7'b1000000, 1'b1);

    // 2. level held 5 cycles counts once
    drive(1, 0, 0, 0);
    push_t("win_rise", 8'h01, 8'h00);
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 0);
      push_t("win_hold", 8'h01, 8'h00);
    end
    drive(0, 0, 0, 0);
    push_t("win_fall", 8'h01, 8'h00);
    drive(0, 0, 0, 0);
    push_t("win_stay", 8'h01, 8'h00);

    // 3. ten single-cycle win pulses
    clear_scores();
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 0, 0);
      mw = bcd_next(mw);
      push_t("win_pulse", mw, 8'h00);
      drive(0, 0, 0, 0);
      push_t("win_gap", mw, 8'h00);
    end
    push_t("win_10", 8'h10, 8'h00);
    n = 0;
    while (idx_at(cyc + 1) != 3 && n < 20) begin
      drive(0, 0, 0, 0);
      n++;
    end
    push_d("disp_w_tens", 8'h10, 8'h00, 4'b0111, 7'b1111001, 1'b1);
    n = 0;
    while (idx_at(cyc + 1) != 2 && n < 20) begin
      drive(0, 0, 0, 0);
      n++;
    end
    push_d("disp_w_ones", 8'h10, 8'h00, 4'b1011, 7'b1000000, 1'b0);

    // 4. lose saturation at 99
    drive(0, 0, 0, 0);
    clear_scores();
    for (int i = 0; i < 101; i++) begin
      drive(0, 1, 0, 0);
      ml = bcd_next(ml);
      if (i == 98) push_t("lose_99", 8'h00, 8'h99);
      else push_t("lose_pulse", 8'h00, ml);
      drive(0, 0, 0, 0);
      push_t("lose_gap", 8'h00, ml);
    end
    push_t("lose_sat", 8'h00, 8'h99);

    // 5. clr beats simultaneous pulses; held level no recount
    drive(0, 0, 0, 0);
    clear_scores();
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 0);
      mw = bcd_next(mw);
      push_t("win_to5", mw, 8'h00);
      drive(0, 0, 0, 0);
    end
    push_t("win_05", 8'h05, 8'h00);
    drive(1, 1, 1, 0);
    push_t("clr_prio", 8'h00, 8'h00);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 0);
      push_t("no_recount", 8'h00, 8'h00);
    end
    drive(0, 0, 0, 0);
    push_t("after_fall", 8'h00, 8'h00);

    // 6. free-run scan with 00/07
    for (int i = 0; i < 7; i++) begin
      drive(0, 1, 0, 0);
      ml = bcd_next(ml);
      push_t("lose_to7", 8'h00, ml);
      drive(0, 0, 0, 0);
    end
    push_t("lose_07", 8'h00, 8'h07);
    for (int i = 0; i < 32; i++) begin
      drive(0, 0, 0, 0);
      n = idx_at(cyc + 1);
      push_d("scan", 8'h00, 8'h07, an_tab[n], s07_tab[n],
             (n == 2) ? 1'b0 : 1'b1);
    end

    // reset mid-run with both levels high, then counted once
    drive(1, 1, 0, 1);
    push_d("rst_mid", 8'h00, 8'h00, 4'b1110, 7'b1000000, 1'b1);
    drive(1, 1, 0, 0);
    push_t("both_after_rst", 8'h01, 8'h01);
    drive(1, 1, 0, 0);
    push_t("both_hold", 8'h01, 8'h01);
    drive(0, 0, 0, 0);
    push_t("both_fall", 8'h01, 8'h01);

    n = 0;
    while (q.size() > 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, required 0",
               q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
